// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_FLAGS_EN to add registered signed-overflow (out_ovf) and zero (out_zero) outputs.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CLA_FLAGS_EN
  ,
  output logic             out_ovf,
  output logic             out_zero
`endif
);

  localparam int unsigned NGRP = WIDTH / GROUP;

  // Handshake
  logic s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic adv1, adv2, s1_load, s2_load;

  always_comb begin
    adv2       = ~s2_valid_q | out_ready;
    adv1       = ~s1_valid_q | adv2;
    s1_load    = in_valid & adv1;
    s2_load    = s1_valid_q & adv2;
    s1_valid_d = adv1 ? in_valid : s1_valid_q;
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
  end

  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;

  // Stage 1: bit terms and group lookahead
  logic [WIDTH-1:0]              bx, t_d, p_d, g_d, t_q;
  // Only the low GROUP-1 bits of each group feed the intra-group carries in stage 2.
  logic [NGRP-1:0][GROUP-2:0]    pl_d, gl_d, pl_q, gl_q;
  logic [NGRP-1:0]               pg_d, gg_d, pg_q, gg_q;
  logic                          c0_d, c0_q;

  always_comb begin
    logic acc;
    bx   = in_sub ? ~in_b : in_b;
    c0_d = in_sub | in_cin;
    t_d  = in_a ^ bx;
    p_d  = in_a | bx;
    g_d  = in_a & bx;
    pl_d = '0;
    gl_d = '0;
    pg_d = '0;
    gg_d = '0;
    for (int k = 0; k < NGRP; k++) begin
      pg_d[k] = &p_d[k*GROUP +: GROUP];
      acc = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
        acc = g_d[k*GROUP+j] | (p_d[k*GROUP+j] & acc);
      end
      gg_d[k] = acc;
      for (int j = 0; j < GROUP - 1; j++) begin
        pl_d[k][j] = p_d[k*GROUP+j];
        gl_d[k][j] = g_d[k*GROUP+j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      t_q        <= '0;
      pl_q       <= '0;
      gl_q       <= '0;
      pg_q       <= '0;
      gg_q       <= '0;
      c0_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        t_q  <= t_d;
        pl_q <= pl_d;
        gl_q <= gl_d;
        pg_q <= pg_d;
        gg_q <= gg_d;
        c0_q <= c0_d;
      end
    end
  end

  // Stage 2: group carries, intra-group carries, sum
  logic [NGRP:0]    gc;
  logic [WIDTH-1:0] c, sum_d, sum_q;
  logic             cout_d, cout_q;

  always_comb begin
    gc[0] = c0_q;
    for (int k = 0; k < NGRP; k++) begin
      gc[k+1] = gg_q[k] | (pg_q[k] & gc[k]);
    end
    c = '0;
    for (int k = 0; k < NGRP; k++) begin
      c[k*GROUP] = gc[k];
      for (int j = 0; j < GROUP - 1; j++) begin
        c[k*GROUP+j+1] = gl_q[k][j] | (pl_q[k][j] & c[k*GROUP+j]);
      end
    end
    sum_d  = t_q ^ c;
    cout_d = gc[NGRP];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

`ifdef CLA_FLAGS_EN
  logic a_msb_d, a_msb_q, bx_msb_d, bx_msb_q;
  logic ovf_d, ovf_q, zero_d, zero_q;

  always_comb begin
    a_msb_d  = in_a[WIDTH-1];
    bx_msb_d = bx[WIDTH-1];
    ovf_d    = (a_msb_q == bx_msb_q) & (sum_d[WIDTH-1] != a_msb_q);
    zero_d   = ~|sum_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q  <= 1'b0;
      bx_msb_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if (s1_load) begin
        a_msb_q  <= a_msb_d;
        bx_msb_q <= bx_msb_d;
      end
      if (s2_load) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_ovf  = ovf_q;
  assign out_zero = zero_q;
`endif

endmodule
